// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus the data-memory access stage: one request per
// entry, stall until answered, then present aligned load data downstream.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_valid,
  input  logic [31:0] EX_pc,
  input  logic [31:0] EX_alu_out,
  input  logic [31:0] EX_cmp_out,
  input  logic [31:0] EX_rs2_out,
  input  logic [4:0]  EX_rd,
  input  logic        EX_load_regfile,
  input  logic [2:0]  EX_regfilemux_sel,
  input  logic        EX_mem_read,
  input  logic        EX_mem_write,
  input  logic [2:0]  EX_funct3,
  input  logic        stall_in,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        MEM_valid,
  output logic [31:0] MEM_pc,
  output logic [31:0] MEM_alu_out,
  output logic [31:0] MEM_cmp_out,
  output logic [4:0]  MEM_rd,
  output logic        MEM_load_regfile,
  output logic [2:0]  MEM_regfilemux_sel,
  output logic [31:0] MEM_load_data,
  output logic        MEM_misaligned
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] cmp_out;
    logic [31:0] rs2_out;
    logic [4:0]  rd;
    logic        load_regfile;
    logic [2:0]  regfilemux_sel;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        misaligned;
  } entry_t;

  state_t      state, state_n;
  entry_t      ent, ent_in;
  logic [31:0] rdata_q, src, shifted;
  logic [1:0]  off;
  logic        mis_raw, mis_in, req_in, in_wait, advance;

  always_comb begin
    case (EX_funct3[1:0])
      2'b01:   mis_raw = EX_alu_out[0];
      2'b10:   mis_raw = |EX_alu_out[1:0];
      default: mis_raw = 1'b0;
    endcase
  end

  assign mis_in = mis_raw & EX_valid & (EX_mem_read | EX_mem_write);
  assign req_in = EX_valid & (EX_mem_read | EX_mem_write) & ~mis_in;

  always_comb begin
    ent_in                = '0;
    ent_in.valid          = EX_valid;
    ent_in.pc             = EX_pc;
    ent_in.alu_out        = EX_alu_out;
    ent_in.cmp_out        = EX_cmp_out;
    ent_in.rs2_out        = EX_rs2_out;
    ent_in.rd             = EX_rd;
    ent_in.load_regfile   = EX_load_regfile & ~mis_in;
    ent_in.regfilemux_sel = EX_regfilemux_sel;
    ent_in.mem_read       = EX_mem_read;
    ent_in.mem_write      = EX_mem_write;
    ent_in.funct3         = EX_funct3;
    ent_in.misaligned     = mis_in;
  end

  assign in_wait   = (state == WAIT);
  assign mem_stall = in_wait & ~dmem_resp;
  assign advance   = ~mem_stall & ~stall_in;

  // A response under a downstream stall parks in HOLD so it is never re-requested.
  always_comb begin
    state_n = state;
    if (advance)                state_n = req_in ? WAIT : IDLE;
    else if (in_wait && dmem_resp) state_n = HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ent     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (advance)              ent     <= ent_in;
      if (in_wait && dmem_resp) rdata_q <= dmem_rdata;
    end
  end

  assign off          = ent.alu_out[1:0];
  assign dmem_read    = in_wait & ent.mem_read;
  assign dmem_write   = in_wait & ent.mem_write;
  assign dmem_address = {ent.alu_out[31:2], 2'b00};

  always_comb begin
    dmem_byte_enable = 4'b0000;
    dmem_wdata       = '0;
    if (dmem_write) begin
      case (ent.funct3[1:0])
        2'b00:   dmem_byte_enable = 4'b0001 << off;
        2'b01:   dmem_byte_enable = 4'b0011 << off;
        default: dmem_byte_enable = 4'b1111;
      endcase
      dmem_wdata = ent.rs2_out << {off, 3'b000};
    end
  end

  // Live bus data while the access completes, captured copy once parked.
  assign src     = in_wait ? dmem_rdata : rdata_q;
  assign shifted = src >> {off, 3'b000};

  always_comb begin
    MEM_load_data = '0;
    if (ent.valid && ent.mem_read && !ent.misaligned) begin
      case (ent.funct3)
        3'b000:  MEM_load_data = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  MEM_load_data = {{16{shifted[15]}}, shifted[15:0]};
        3'b010:  MEM_load_data = shifted;
        3'b100:  MEM_load_data = {24'b0, shifted[7:0]};
        3'b101:  MEM_load_data = {16'b0, shifted[15:0]};
        default: MEM_load_data = '0;
      endcase
    end
  end

  assign MEM_valid          = ent.valid;
  assign MEM_pc             = ent.pc;
  assign MEM_alu_out        = ent.alu_out;
  assign MEM_cmp_out        = ent.cmp_out;
  assign MEM_rd             = ent.rd;
  assign MEM_load_regfile   = ent.load_regfile;
  assign MEM_regfilemux_sel = ent.regfilemux_sel;
  assign MEM_misaligned     = ent.misaligned;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model with a memory responder,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid, EX_load_regfile, EX_mem_read, EX_mem_write, stall_in;
  logic [31:0] EX_pc, EX_alu_out, EX_cmp_out, EX_rs2_out;
  logic [4:0]  EX_rd;
  logic [2:0]  EX_regfilemux_sel, EX_funct3;
  logic        dmem_read, dmem_write, dmem_resp, mem_stall;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_enable;
  logic        MEM_valid, MEM_load_regfile, MEM_misaligned;
  logic [31:0] MEM_pc, MEM_alu_out, MEM_cmp_out, MEM_load_data;
  logic [4:0]  MEM_rd;
  logic [2:0]  MEM_regfilemux_sel;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_alu_out(EX_alu_out),
    .EX_cmp_out(EX_cmp_out), .EX_rs2_out(EX_rs2_out), .EX_rd(EX_rd),
    .EX_load_regfile(EX_load_regfile), .EX_regfilemux_sel(EX_regfilemux_sel),
    .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write), .EX_funct3(EX_funct3),
    .stall_in(stall_in), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_byte_enable(dmem_byte_enable),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .MEM_valid(MEM_valid), .MEM_pc(MEM_pc),
    .MEM_alu_out(MEM_alu_out), .MEM_cmp_out(MEM_cmp_out), .MEM_rd(MEM_rd),
    .MEM_load_regfile(MEM_load_regfile), .MEM_regfilemux_sel(MEM_regfilemux_sel),
    .MEM_load_data(MEM_load_data), .MEM_misaligned(MEM_misaligned)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, alu, cmp, rs2;
    logic [4:0]  rd;
    logic        lr;
    logic [2:0]  mux;
    logic        mr, mw;
    logic [2:0]  f3;
    logic        mis;
  } ent_t;

  // Model: the current entry, whether its access is still unanswered, last captured data.
  ent_t        m;
  logic        pending;
  int          cnt;
  logic [31:0] cap;
  logic [31:0] mem [16];
  int          next_lat = -1;
  logic        spurious_en = 1'b0;
  int          total = 0, passed = 0, nfail = 0;
  logic        s_read, s_write, s_stall, s_valid, s_mis;
  logic [31:0] s_addr, s_wdata, s_ld;
  logic [3:0]  s_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic misal(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < nbytes(f3); i++) be[int'(off) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] src,
                                         input logic [1:0] off);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = src[8*(int'(off) + i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic set_ex(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2);
    EX_valid = v; EX_mem_read = mr; EX_mem_write = mw; EX_funct3 = f3;
    EX_alu_out = alu; EX_rs2_out = rs2;
    EX_pc = $urandom; EX_cmp_out = 32'($urandom_range(0, 1));
    EX_rd = 5'($urandom); EX_load_regfile = 1'($urandom); EX_regfilemux_sel = 3'($urandom);
  endtask

  // One cycle: responder drives, outputs compared against the model, model advances.
  task automatic step();
    logic        exp_stall, adv;
    logic [31:0] ld_exp, w;
    logic [3:0]  be;
    dmem_resp = 1'b0;
    dmem_rdata = $urandom;
    if (!rst) begin
      if (pending) begin
        if (cnt == 0) begin
          dmem_resp = 1'b1;
          if (m.mr) dmem_rdata = mem[m.alu[5:2]];
        end
      end else if (spurious_en && $urandom_range(0, 7) == 0) dmem_resp = 1'b1;
    end
    #1;
    exp_stall = pending && !dmem_resp;
    s_read = dmem_read; s_write = dmem_write; s_stall = mem_stall; s_valid = MEM_valid;
    s_mis = MEM_misaligned; s_addr = dmem_address; s_wdata = dmem_wdata; s_be = dmem_byte_enable;
    s_ld = MEM_load_data;
    chk("dmem_read", 32'(dmem_read), 32'(pending && m.mr));
    chk("dmem_write", 32'(dmem_write), 32'(pending && m.mw));
    chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
    chk("dmem_address", dmem_address, {m.alu[31:2], 2'b00});
    chk("byte_enable", 32'(dmem_byte_enable),
        32'((pending && m.mw) ? exp_be(m.f3, m.alu[1:0]) : 4'b0000));
    if (pending && m.mw) chk("wdata", dmem_wdata, m.rs2 << (8 * m.alu[1:0]));
    chk("MEM_valid", 32'(MEM_valid), 32'(m.valid));
    chk("MEM_pc", MEM_pc, m.pc);
    chk("MEM_alu_out", MEM_alu_out, m.alu);
    chk("MEM_cmp_out", MEM_cmp_out, m.cmp);
    chk("MEM_rd", 32'(MEM_rd), 32'(m.rd));
    chk("MEM_load_regfile", 32'(MEM_load_regfile), 32'(m.lr));
    chk("MEM_mux_sel", 32'(MEM_regfilemux_sel), 32'(m.mux));
    chk("MEM_misaligned", 32'(MEM_misaligned), 32'(m.mis));
    if (!exp_stall) begin
      ld_exp = (m.valid && m.mr && !m.mis) ?
               ld_val(m.f3, pending ? dmem_rdata : cap, m.alu[1:0]) : 32'h0;
      chk("MEM_load_data", MEM_load_data, ld_exp);
    end
    if (rst) begin
      m = '0; pending = 1'b0; cap = '0;
    end else begin
      adv = !exp_stall && !stall_in;
      if (pending && dmem_resp) begin
        cap = dmem_rdata;
        if (m.mw) begin
          be = exp_be(m.f3, m.alu[1:0]);
          w = m.rs2 << (8 * m.alu[1:0]);
          for (int i = 0; i < 4; i++) if (be[i]) mem[m.alu[5:2]][8*i +: 8] = w[8*i +: 8];
        end
        pending = 1'b0;
      end else if (pending) cnt--;
      if (adv) begin
        m.valid = EX_valid; m.pc = EX_pc; m.alu = EX_alu_out; m.cmp = EX_cmp_out;
        m.rs2 = EX_rs2_out; m.rd = EX_rd; m.mux = EX_regfilemux_sel;
        m.mr = EX_mem_read; m.mw = EX_mem_write; m.f3 = EX_funct3;
        m.mis = EX_valid && (EX_mem_read || EX_mem_write) && misal(EX_funct3, EX_alu_out);
        m.lr = EX_load_regfile && !m.mis;
        pending = m.valid && (m.mr || m.mw) && !m.mis;
        cnt = (next_lat >= 0) ? next_lat : $urandom_range(0, 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic bubble();
    set_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [2:0] rd3, st3;
    int kind;
    logic [2:0] f3;
    logic [31:0] alu;
    m = '0; pending = 1'b0; cap = '0; cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst = 1'b1; stall_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst MEM_valid", 32'(MEM_valid), 32'h0);
    chk("rst MEM_pc", MEM_pc, 32'h0);
    chk("rst dmem_read", 32'({dmem_read, dmem_write}), 32'h0);
    chk("rst mem_stall", 32'(mem_stall), 32'h0);
    chk("rst dmem_address", dmem_address, 32'h0);
    chk("rst MEM_load_data", MEM_load_data, 32'h0);
    rst = 1'b0;

    // lw 0x100, two stall cycles then response
    mem[0] = 32'hDEADBEEF; next_lat = 2;
    set_ex(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0); step();
    bubble();
    for (int i = 0; i < 3; i++) begin step(); rd3[2-i] = s_read; st3[2-i] = s_stall; end
    chk("lw read cycles", 32'(rd3), 32'h7);
    chk("lw stall pattern", 32'(st3), 32'h6);
    chk("lw data", s_ld, 32'hDEADBEEF);

    // sb at 0x203
    next_lat = 1;
    set_ex(1'b1, 1'b0, 1'b1, 3'd0, 32'h203, 32'h000000AB); step();
    bubble(); step();
    chk("sb address", s_addr, 32'h200);
    chk("sb byte_enable", 32'(s_be), 32'h8);
    chk("sb wdata", s_wdata, 32'hAB000000);
    step();
    chk("sb write held", 32'(s_write), 32'h1);

    // lh / lhu at 0x302
    next_lat = 0; mem[0] = 32'h80011234;
    set_ex(1'b1, 1'b1, 1'b0, 3'd1, 32'h302, 32'h0); step();
    set_ex(1'b1, 1'b1, 1'b0, 3'd5, 32'h302, 32'h0); step();
    chk("lh data", s_ld, 32'hFFFF8001);
    bubble(); step();
    chk("lhu data", s_ld, 32'h00008001);

    // response under stall_in: park, no re-request, advance once
    mem[0] = 32'h11223344;
    set_ex(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0); step();
    bubble(); stall_in = 1'b1; step();
    chk("hold resp data", s_ld, 32'h11223344);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold no rereq", 32'(s_read), 32'h0);
      chk("hold data", s_ld, 32'h11223344);
    end
    stall_in = 1'b0; step();
    chk("hold release valid", 32'(s_valid), 32'h1);
    step();
    chk("advance once", 32'(s_valid), 32'h0);

    // back-to-back sw then lw
    set_ex(1'b1, 1'b0, 1'b1, 3'd2, 32'h104, 32'hCAFEF00D); step();
    set_ex(1'b1, 1'b1, 1'b0, 3'd2, 32'h104, 32'h0); step();
    chk("b2b sw", 32'({s_write, s_read}), 32'h2);
    bubble(); step();
    chk("b2b lw", 32'({s_write, s_read}), 32'h1);
    chk("b2b lw data", s_ld, 32'hCAFEF00D);
    step();
    chk("b2b idle", 32'({s_write, s_read}), 32'h0);

    // misaligned sw
    set_ex(1'b1, 1'b0, 1'b1, 3'd2, 32'h102, 32'h55); step();
    bubble(); step();
    chk("mis no write", 32'({s_write, s_stall}), 32'h0);
    chk("mis flag", 32'(s_mis), 32'h1);

    // reset during WAIT
    next_lat = 5;
    set_ex(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0); step();
    bubble(); step();
    chk("rst-wait read", 32'(s_read), 32'h1);
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("rst-wait drop", 32'(s_read), 32'h0);
    chk("rst-wait valid", 32'(s_valid), 32'h0);

    // randomized traffic
    next_lat = -1; spurious_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      stall_in = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 2);
      if (kind == 1)
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom);
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu = alu & ~32'(nbytes(f3) - 1);
      set_ex($urandom_range(0, 99) < 85, kind == 1, kind == 2, f3, alu, $urandom);
      step();
    end
    rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; also holds the EX/MEM pipeline register.
- Latches the execute stage's ALU result, compare result, store data and control each time the pipeline advances.
- Performs one data-memory read or write per entry, using a request/response handshake.
- Stalls the pipeline while that access is outstanding, and presents load-aligned data plus pass-through fields to the MEM/WB register and the forwarding network.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- EX_valid  in  1  execute stage holds a real instruction
- EX_pc  in  32  instruction PC
- EX_alu_out  in  32  ALU result / effective address
- EX_cmp_out  in  32  compare result, zero-extended
- EX_rs2_out  in  32  store data
- EX_rd  in  5  destination register
- EX_load_regfile  in  1  instruction writes rd
- EX_regfilemux_sel  in  3  writeback select, passed through
- EX_mem_read  in  1  load instruction
- EX_mem_write  in  1  store instruction
- EX_funct3  in  3  load_funct3_t / store width
- stall_in  in  1  downstream or global stall; blocks advance
- dmem_read  out  1  data read request
- dmem_write  out  1  data write request
- dmem_address  out  32  word-aligned address, bits [1:0] = 0
- dmem_byte_enable  out  4  write byte mask
- dmem_wdata  out  32  lane-shifted store data
- dmem_resp  in  1  access complete, one-cycle pulse
- dmem_rdata  in  32  read data, valid with dmem_resp
- mem_stall  out  1  pipeline must hold
- MEM_valid, MEM_pc, MEM_alu_out, MEM_cmp_out, MEM_rd, MEM_load_regfile, MEM_regfilemux_sel  out  as inputs  registered entry
- MEM_load_data  out  32  sign/zero-extended load value
- MEM_misaligned  out  1  entry's access was suppressed as misaligned

Behaviour:
- Reset (synchronous, active-high):
  - Entry cleared: MEM_valid = 0 and every MEM_* field = 0.
  - State = IDLE; rdata_q = 0.
  - All dmem_* outputs = 0; mem_stall = 0.
- Advance rule:
  - advance = !mem_stall && !stall_in.
  - On advance the entry register loads all EX_* inputs; otherwise it holds.
  - An EX_valid = 0 input loads a bubble: no access, no stall.
- Misalignment:
  - Defined as lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] != 0.
  - Detected when the entry is loaded. A misaligned entry makes no request, sets MEM_misaligned = 1 and forces MEM_load_regfile = 0.
- States:
  - IDLE: no outstanding access. On advance, go to WAIT if the incoming entry is valid, has mem_read or mem_write set and is aligned; otherwise stay in IDLE.
  - WAIT: dmem_read = entry.mem_read; dmem_write = entry.mem_write.
    - Request lines stay steady until dmem_resp; address, data and mask are stable throughout.
    - mem_stall = !dmem_resp.
    - On dmem_resp: rdata_q <= dmem_rdata.
    - If stall_in = 1, go to HOLD.
    - Otherwise advance this same edge; the next state follows the IDLE rule for the new entry, so back-to-back accesses are allowed.
  - HOLD: access done, no request, mem_stall = 0. Wait for stall_in = 0, then advance and follow the IDLE rule.
- Request rules:
  - A request is never re-issued for an entry already answered.
  - dmem_resp outside WAIT is ignored.
- Store lanes (off = alu_out[1:0]):
  - sb: byte_enable = 0001 << off; wdata = rs2 << 8*off.
  - sh: byte_enable = 0011 << off; wdata = rs2 << 8*off.
  - sw: byte_enable = 1111; wdata = rs2.
  - byte_enable = 0000 whenever dmem_write = 0.
- Load data:
  - src = dmem_rdata in WAIT, else rdata_q.
  - Shift src right by 8*off, then apply lb/lh (sign-extend), lbu/lhu (zero-extend) or lw.
  - MEM_load_data = 0 for non-loads.
- dmem_address = {alu_out[31:2], 2'b00} in all states.
- Reset mid-access (rst during WAIT) returns to IDLE, drops the request next cycle and discards any later response.

Test Plan:
- lw from 0x100; resp after 3 cycles with rdata 0xDEADBEEF -> dmem_read high for 3 cycles; mem_stall = 1,1,0; MEM_load_data = 0xDEADBEEF on the resp cycle.
- sb at 0x203 with rs2 = 0x000000AB -> dmem_address = 0x200, byte_enable = 1000, wdata = 0xAB000000, dmem_write held until resp.
- lh at 0x302 with rdata 0x8001xxxx -> MEM_load_data = 0xFFFF8001; lhu at the same address -> 0x00008001.
- Response arrives while stall_in = 1 -> HOLD with no re-request; after stall_in drops, MEM_load_data remains the captured value and the entry advances once.
- Back-to-back sw then lw, each with a single-cycle resp -> second request starts the cycle after the first resp, with no gap cycle and no duplicated write.
- sw at 0x102 -> no dmem_write, mem_stall = 0, MEM_misaligned = 1. Separately, rst asserted in WAIT -> dmem_read = 0 the next cycle and MEM_valid = 0.
